uart_rx_buffer: RTL and testbench

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer.sv | 112 +++++++++++
 tb/tb_uart_rx_buffer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// Byte FIFO fed by a UART receiver and drained one byte per debounced press of btnC.
// The head byte, occupancy and status flags are all registered.
module uart_rx_buffer #(
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  input  logic                         btnC,
  output logic [7:0]                   led,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2;
  logic          vld1, vld2;
  logic          stable;
  logic          armed;
  logic [DW-1:0] db_cnt;
  logic          db_hit_c, pop_c, do_pop_c, do_wr_c;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CW-1:0] count_nxt;
  logic [7:0]    head_nxt;

  // Button synchronizer; vld* marks when sync2 holds a real sample after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      vld1  <= 1'b0;
      vld2  <= 1'b0;
    end else begin
      sync1 <= btnC;
      sync2 <= sync1;
      vld1  <= 1'b1;
      vld2  <= vld1;
    end
  end

  assign db_hit_c = (sync2 != stable) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  // A press only counts once the button has been seen released since reset
  assign pop_c    = db_hit_c && sync2 && armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      db_cnt <= '0;
      armed  <= 1'b0;
    end else begin
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_hit_c) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
      if (vld2 && !sync2 && !stable) armed <= 1'b1;
    end
  end

  assign do_pop_c   = pop_c && !empty;
  assign do_wr_c    = rx_valid && (!full || do_pop_c);
  assign rd_ptr_inc = rd_ptr + PW'(1);

  // Next occupancy and next head byte, so led tracks the edge that changes the FIFO
  always_comb begin
    count_nxt = count;
    head_nxt  = led;
    if (do_wr_c && !do_pop_c)      count_nxt = count + CW'(1);
    else if (do_pop_c && !do_wr_c) count_nxt = count - CW'(1);

    if (do_pop_c && count == CW'(1)) head_nxt = do_wr_c ? rx_data : 8'h00;
    else if (do_pop_c)               head_nxt = mem[rd_ptr_inc];
    else if (do_wr_c && empty)       head_nxt = rx_data;
  end

  always_ff @(posedge clk) begin
    if (do_wr_c) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      led      <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (do_wr_c)  wr_ptr <= wr_ptr + PW'(1);
      if (do_pop_c) rd_ptr <= rd_ptr_inc;
      count    <= count_nxt;
      full     <= (count_nxt == CW'(DEPTH));
      empty    <= (count_nxt == '0);
      led      <= head_nxt;
      if (rx_valid && full && !do_pop_c) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer at DEPTH=4, DEBOUNCE_CYCLES=4.
module tb_uart_rx_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DB    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       btnC;
  logic [7:0] led;
  logic [2:0] count;
  logic       full, empty, overflow;

  uart_rx_buffer #(.DEPTH(DEPTH), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .btnC(btnC),
    .led(led), .count(count), .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  logic       m_ovf;
  int         lat = 6;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".led"}, 32'(led), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic wr(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovf = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Clean press: wait (bounded) for the pop, check its latency, then release
  task automatic press(input string tag);
    logic [2:0] c0;
    int         got;
    c0   = count;
    got  = 0;
    btnC = 1'b1;
    for (int k = 1; k <= 20 && got == 0; k++) begin
      @(negedge clk);
      if (count != c0) got = k;
    end
    if (got == 0) begin
      check({tag, ".timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, ".latency"}, 32'(got >= 5 && got <= 7), 32'd1);
      lat = got;
    end
    if (q.size() > 0) void'(q.pop_front());
    btnC = 1'b0;
    repeat (DB + 6) @(negedge clk);
    check_state(tag);
  endtask

  // Press with rx_valid aligned to the pop edge
  task automatic coincide(input logic [7:0] b);
    btnC = 1'b1;
    repeat (lat - 1) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    if (q.size() > 0) void'(q.pop_front());
    q.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0;
    btnC     = 1'b0;
    repeat (DB + 6) @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges, checked before any clock
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_state({tag, ".async"});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; btnC = 1'b0; m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_state("post_reset");

    // Two writes then a clean pop
    wr(8'hA5); wr(8'h3C);
    check_state("s1_wr");
    press("s1_pop");

    // Bouncing button then a steady hold gives exactly one pop
    wr(8'h11); wr(8'h22);
    check_state("s2_wr");
    for (int i = 0; i < 10; i++) begin
      btnC = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    btnC = 1'b1;
    repeat (10) @(negedge clk);
    btnC = 1'b0;
    void'(q.pop_front());
    repeat (DB + 6) @(negedge clk);
    check_state("s2_bounce");
    press("s2_drain1");
    press("s2_drain2");

    // Overflow on the fifth write, then drain
    for (int b = 1; b <= 5; b++) wr(8'(b));
    check_state("s3_full");
    for (int i = 0; i < 4; i++) press($sformatf("s3_pop%0d", i));

    // Write into a full FIFO on the pop edge
    do_reset("s4_rst");
    wr(8'h10); wr(8'h20); wr(8'h30); wr(8'h40);
    check_state("s4_full");
    coincide(8'h77);
    check_state("s4_coinc");
    for (int i = 0; i < 4; i++) press($sformatf("s4_pop%0d", i));

    // Pop on empty coincident with a write
    coincide(8'h5A);
    check_state("s5_coinc");

    // Three bytes plus overflow, then async reset with a pending press held through release
    wr(8'h61); wr(8'h62); wr(8'h63); wr(8'h64);
    press("s6_pre");
    btnC = 1'b1;
    repeat (2) @(negedge clk);
    do_reset("s6_rst");
    repeat (3) @(negedge clk);
    wr(8'hAA);
    repeat (12) @(negedge clk);
    check_state("s6_held");
    btnC = 1'b0;
    repeat (DB + 6) @(negedge clk);
    check_state("s6_released");
    press("s6_pop");

    // Six bytes through the FIFO across pointer wrap
    wr(8'hC1); wr(8'hC2); wr(8'hC3); wr(8'hC4);
    check_state("s6_wrap_full");
    press("s6_wp0"); press("s6_wp1");
    wr(8'hC5); wr(8'hC6);
    check_state("s6_wrap_refill");
    for (int i = 0; i < 4; i++) press($sformatf("s6_wq%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
